bsg_segmented_fill_buffer: RTL and testbench
============================================

Name: bsg_segmented_fill_buffer

Overview:
- Write-side producer for the segmented 2:1 line mux (5 x 128-bit segments).
- Accepts 128-bit segments one per handshake, each tagged with a segment index, and accumulates them into a 640-bit line plus a 5-bit written-segment mask.
- Presents the line as data_o and the mask as sel_o once all segments are written or a flush is requested. sel_o drives the mux segment selects directly; data_o feeds its data1 side.

Parameters:
- segments_p, 5, number of segments per line
- segment_width_p, 128, bits per segment
- idx_width_lp (derived), $clog2(segments_p) = 3, width of the segment index

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-high reset
- seg_v_i  input  1  segment write valid
- seg_ready_o  output  1  buffer can accept a segment this cycle
- seg_idx_i  input  idx_width_lp  target segment index
- seg_data_i  input  segment_width_p  segment payload
- flush_i  input  1  emit a partial line
- v_o  output  1  line valid
- yumi_i  input  1  consumer takes the line; legal only while v_o=1
- data_o  output  segments_p*segment_width_p  assembled line; segment k at bits [k*128 +: 128]
- sel_o  output  segments_p  written mask; bit k=1 means segment k holds new data

Behaviour:
- States: FILL, DONE (2-state FSM).
- Reset (reset_i=1 at a posedge):
  - state<=FILL, mask<=0, v_o=0.
  - seg_ready_o=0 while reset_i is high; seg_ready_o=1 on the first cycle after reset deasserts.
  - Reset mid-line discards the partial line, and any v_o drops the next cycle.
- Outputs by state:
  - seg_ready_o = (state==FILL) & ~reset_i.
  - v_o = (state==DONE).
  - sel_o = mask register.
  - data_o = storage registers; registered, no combinational path from any input.
- FILL, write accepted (seg_v_i & seg_ready_o, seg_idx_i < segments_p):
  - storage[idx]<=seg_data_i and mask[idx]<=1 at the posedge.
  - A rewrite of an already-written index overwrites the data; the mask is unchanged.
- FILL, out-of-range index (seg_idx_i >= segments_p): the write is dropped, nothing changes, and seg_ready_o still reads 1 (handshake completes).
- FILL -> DONE when either:
  - the next mask is all ones, or
  - flush_i=1 and the next mask is nonzero.
  - Latency: v_o=1 on the cycle after the completing write.
- Simultaneous write and flush in FILL: the write is applied first, then the transition is evaluated.
- flush_i with an empty mask and no valid write: ignored, stays in FILL.
- DONE:
  - seg_ready_o=0; seg_v_i and flush_i are ignored.
  - data_o and sel_o are held stable until yumi_i.
- DONE, yumi_i=1:
  - next state FILL, mask<=0.
  - Storage is not cleared; stale contents stay visible only as masked-off segments.
  - A new line can start the cycle after yumi_i, giving a minimum 1 bubble cycle between lines.
- yumi_i while in FILL: ignored (protocol violation; assertion fires in simulation).
- Back-to-back: 5 consecutive cycles of in-range writes complete a line, and v_o rises on cycle 6.

Optional Feature:
- BSG_SEGMENTED_FILL_ZERO_EN
  - Defined: data_o segment k is forced to 0 whenever sel_o[k]=0, so the line carries no stale data. The storage itself is unchanged.
  - Undefined: data_o exposes raw storage, and unwritten segments show the previous line's data or post-reset X.
- All handshake timing is identical either way.

Decomposition:
- Shared package bsg_segmented_fill_pkg:
  - state enum (e_fill, e_done)
  - default segment count and width constants
  - line-width helper (segments*width)
- Sub-module bsg_segmented_fill_seg:
  - one segment's data register plus its mask bit
  - inputs: write enable, clear, data
  - replicated segments_p times in a generate loop
- The top level holds only the FSM and the all-ones/nonzero reductions.

Test Plan:
- Post-reset check -> v_o=0, sel_o=5'b00000, seg_ready_o=1 on the first cycle with reset_i=0.
- Write idx 0..4 with data 128'h...A0..A4 on consecutive cycles -> v_o=1 on the next cycle, sel_o=5'b11111, data_o[511:384]=A3; yumi_i -> sel_o=0, seg_ready_o=1 the next cycle.
- Write idx 2=128'h55, then idx 2=128'h66, then flush_i -> sel_o=5'b00100, data_o[383:256]=128'h66.
  - With ZERO_EN: all other segments read 0.
- Write idx 7 (out of range) plus idx 1, then flush -> sel_o=5'b00010; the idx-7 write has no effect.
- In DONE, drive seg_v_i=1 idx 0 and flush_i=1 for 3 cycles -> data_o and sel_o unchanged, seg_ready_o=0.
- Write idx 0 and idx 3, assert reset_i for 1 cycle, then flush with no write -> sel_o=0, v_o stays 0 (flush of an empty mask is ignored).

Source files
------------

// File: rtl/bsg_segmented_fill_pkg.sv
// Shared types and constants for the segmented fill buffer and its segment slices.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bsg_segmented_fill_pkg;

    // Default line geometry: five 128-bit segments feeding the 2:1 line mux.
    localparam int default_segments_lp      = 5;
    localparam int default_segment_width_lp = 128;

    // Two-state fill FSM: accumulate segments, then hold the line for the consumer.
    typedef enum logic [0:0] {
        e_fill = 1'b0,
        e_done = 1'b1
    } state_e;

    // Total line width in bits for a given segment count and segment width.
    function automatic int line_width(input int segments, input int width);
        return segments * width;
    endfunction

endpackage

// File: rtl/bsg_segmented_fill_seg.sv
// One line segment: payload register plus its written-mask bit.
// Latency: data and mask update on the clock edge of the write; outputs are registered.
// Backpressure: none; the parent only raises we_i when the handshake completes.
module bsg_segmented_fill_seg
    import bsg_segmented_fill_pkg::*;
#(
    parameter int width_p = default_segment_width_lp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               we_i,
    input  logic               clear_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o,
    output logic               mask_o
);

    logic [width_p-1:0] data_r;
    logic               mask_r;

    // Payload is never reset or cleared; the mask bit alone says whether it is current.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data_r <= data_i;
        end
    end

    // Mask bit: set on any write (rewrites leave it set), cleared on reset or line hand-off.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            mask_r <= 1'b0;
        end else if (we_i) begin
            mask_r <= 1'b1;
        end
    end

    assign data_o = data_r;
    assign mask_o = mask_r;

endmodule

// File: rtl/bsg_segmented_fill_buffer.sv
// Accumulates indexed 128-bit segments into a 5-segment line plus written mask (optional BSG_SEGMENTED_FILL_ZERO_EN zeroes unwritten segments on data_o).
// Latency: v_o rises the cycle after the write (or flush) that completes the line; data_o/sel_o are registered.
// Backpressure: seg_ready_o is low while a finished line waits for yumi_i, and during reset; one bubble cycle between lines.
module bsg_segmented_fill_buffer
    import bsg_segmented_fill_pkg::*;
#(
    parameter  int segments_p      = default_segments_lp,
    parameter  int segment_width_p = default_segment_width_lp,
    localparam int idx_width_lp    = $clog2(segments_p),
    localparam int line_width_lp   = line_width(segments_p, segment_width_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       seg_v_i,
    output logic                       seg_ready_o,
    input  logic [idx_width_lp-1:0]    seg_idx_i,
    input  logic [segment_width_p-1:0] seg_data_i,
    input  logic                       flush_i,
    output logic                       v_o,
    input  logic                       yumi_i,
    output logic [line_width_lp-1:0]   data_o,
    output logic [segments_p-1:0]      sel_o
);

    localparam logic [0:0] state_fill_lp = e_fill;
    localparam logic [0:0] state_done_lp = e_done;

    logic [0:0]            state_r;
    logic [0:0]            state_n;
    logic                  clear_line;
    logic                  write_fire;
    logic [segments_p-1:0] write_onehot;
    logic [segments_p-1:0] mask_r;
    logic [segments_p-1:0] mask_n;
    logic                  mask_full_n;
    logic                  mask_any_n;
    logic [line_width_lp-1:0] storage;

    // Ready only while filling and never in a reset cycle.
    assign seg_ready_o = (state_r == state_fill_lp) && !reset_i;
    assign v_o         = (state_r == state_done_lp);
    assign write_fire  = seg_v_i && seg_ready_o;

    // Decode the target index; an out-of-range index matches no slot, so the write vanishes
    // while the handshake still completes.
    always_comb begin
        write_onehot = '0;
        for (int k = 0; k < segments_p; k++) begin
            if (write_fire && (seg_idx_i == idx_width_lp'(k))) begin
                write_onehot[k] = 1'b1;
            end
        end
    end

    // Mask as it will be after this cycle's write, so a write and a flush in the same
    // cycle see the write applied first.
    assign mask_n      = mask_r | write_onehot;
    assign mask_full_n = &mask_n;
    assign mask_any_n  = |mask_n;

    // Next-state: finish the line when full or flushed non-empty; release on yumi.
    always_comb begin
        state_n    = state_r;
        clear_line = 1'b0;
        case (state_r)
            state_fill_lp: begin
                if (mask_full_n || (flush_i && mask_any_n)) begin
                    state_n = state_done_lp;
                end
            end
            state_done_lp: begin
                if (yumi_i) begin
                    state_n    = state_fill_lp;
                    clear_line = 1'b1;
                end
            end
            default: begin
                state_n = state_fill_lp;
            end
        endcase
    end

    // State register; reset abandons any partial or finished line.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= state_fill_lp;
        end else begin
            state_r <= state_n;
        end
    end

    for (genvar k = 0; k < segments_p; k++) begin : g_seg
        logic [segment_width_p-1:0] seg_data;

        bsg_segmented_fill_seg #(
            .width_p (segment_width_p)
        ) u_seg (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .we_i    (write_onehot[k]),
            .clear_i (clear_line),
            .data_i  (seg_data_i),
            .data_o  (seg_data),
            .mask_o  (mask_r[k])
        );

        assign storage[k*segment_width_p +: segment_width_p] = seg_data;

`ifdef BSG_SEGMENTED_FILL_ZERO_EN
        // Unwritten segments present as zero so the line never carries stale payload.
        assign data_o[k*segment_width_p +: segment_width_p] =
            mask_r[k] ? seg_data : '0;
`else
        // Raw storage; unwritten segments show whatever they last held.
        assign data_o[k*segment_width_p +: segment_width_p] = seg_data;
`endif
    end

    assign sel_o = mask_r;

    // The consumer may only take a line that is being offered.
    a_yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
    );

    // While a line is offered its contents and mask must not move until it is taken.
    a_hold_until_yumi: assert property (
        @(posedge clk_i) disable iff (reset_i)
        (v_o && !yumi_i) |=> (v_o && $stable(sel_o) && $stable(storage))
    );

    // A finished line always has at least one written segment.
    a_done_nonempty: assert property (
        @(posedge clk_i) disable iff (reset_i) v_o |-> (|sel_o)
    );

endmodule

// File: tb/tb_bsg_segmented_fill_buffer.sv
// Directed self-checking bench for bsg_segmented_fill_buffer (honours BSG_SEGMENTED_FILL_ZERO_EN).
// Latency: inputs driven 1 ns after each rising edge, outputs sampled 1 ns after that.
// Backpressure: the stimulus only writes while seg_ready_o is expected high.
module tb_bsg_segmented_fill_buffer;

    localparam int segs_lp = 5;
    localparam int w_lp    = 128;
    localparam int line_lp = segs_lp * w_lp;

    logic               clk = 1'b0;
    logic               reset_i;
    logic               seg_v_i;
    logic               seg_ready_o;
    logic [2:0]         seg_idx_i;
    logic [w_lp-1:0]    seg_data_i;
    logic               flush_i;
    logic               v_o;
    logic               yumi_i;
    logic [line_lp-1:0] data_o;
    logic [segs_lp-1:0] sel_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bsg_segmented_fill_buffer #(
        .segments_p      (segs_lp),
        .segment_width_p (w_lp)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .seg_v_i     (seg_v_i),
        .seg_ready_o (seg_ready_o),
        .seg_idx_i   (seg_idx_i),
        .seg_data_i  (seg_data_i),
        .flush_i     (flush_i),
        .v_o         (v_o),
        .yumi_i      (yumi_i),
        .data_o      (data_o),
        .sel_o       (sel_o)
    );

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [line_lp-1:0] obs,
                         input logic [line_lp-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: return 1 ns after the rising edge, ready to drive.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a segment write for the next edge.
    task automatic drive_write(input logic [2:0] idx, input logic [w_lp-1:0] dat);
        seg_v_i    = 1'b1;
        seg_idx_i  = idx;
        seg_data_i = dat;
    endtask

    task automatic idle_inputs();
        seg_v_i    = 1'b0;
        seg_idx_i  = 3'd0;
        seg_data_i = '0;
        flush_i    = 1'b0;
        yumi_i     = 1'b0;
    endtask

    // Take the offered line and return to fill.
    task automatic take_line();
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        #1;
    endtask

    logic [w_lp-1:0] exp_seg;

    initial begin
        reset_i = 1'b1;
        idle_inputs();

        // Reset
        step();
        step();
        check("ready_in_reset", line_lp'(seg_ready_o), line_lp'(1'b0));
        check("v_in_reset",     line_lp'(v_o),         line_lp'(1'b0));
        reset_i = 1'b0;
        #1;
        check("ready_after_reset", line_lp'(seg_ready_o), line_lp'(1'b1));
        check("v_after_reset",     line_lp'(v_o),         line_lp'(1'b0));
        check("sel_after_reset",   line_lp'(sel_o),       line_lp'(5'b00000));

        // Full line, back-to-back writes idx 0..4
        for (int i = 0; i < 5; i++) begin
            drive_write(3'(i), w_lp'(8'hA0 + i));
            step();
            if (i == 3) begin
                check("v_before_last_write", line_lp'(v_o), line_lp'(1'b0));
            end
        end
        idle_inputs();
        #1;
        check("full_v",      line_lp'(v_o),         line_lp'(1'b1));
        check("full_sel",    line_lp'(sel_o),       line_lp'(5'b11111));
        check("full_seg3",   line_lp'(data_o[511:384]), line_lp'(8'hA3));
        check("full_seg0",   line_lp'(data_o[127:0]),   line_lp'(8'hA0));
        check("full_ready",  line_lp'(seg_ready_o), line_lp'(1'b0));
        take_line();
        check("yumi_sel",    line_lp'(sel_o),       line_lp'(5'b00000));
        check("yumi_v",      line_lp'(v_o),         line_lp'(1'b0));
        check("yumi_ready",  line_lp'(seg_ready_o), line_lp'(1'b1));

        // Rewrite of idx 2, then flush
        drive_write(3'd2, w_lp'(8'h55));
        step();
        drive_write(3'd2, w_lp'(8'h66));
        step();
        idle_inputs();
        #1;
        check("rewrite_sel_pre", line_lp'(sel_o), line_lp'(5'b00100));
        check("rewrite_v_pre",   line_lp'(v_o),   line_lp'(1'b0));
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        check("rewrite_v",    line_lp'(v_o),   line_lp'(1'b1));
        check("rewrite_sel",  line_lp'(sel_o), line_lp'(5'b00100));
        check("rewrite_seg2", line_lp'(data_o[383:256]), line_lp'(8'h66));
`ifdef BSG_SEGMENTED_FILL_ZERO_EN
        check("rewrite_seg0_zero", line_lp'(data_o[127:0]),   line_lp'(0));
        check("rewrite_seg4_zero", line_lp'(data_o[639:512]), line_lp'(0));
`else
        check("rewrite_seg0_stale", line_lp'(data_o[127:0]),   line_lp'(8'hA0));
        check("rewrite_seg4_stale", line_lp'(data_o[639:512]), line_lp'(8'hA4));
`endif
        take_line();

        // Out-of-range index is dropped but the handshake completes
        drive_write(3'd7, {w_lp{1'b1}});
        step();
        idle_inputs();
        #1;
        check("oor_sel",   line_lp'(sel_o),       line_lp'(5'b00000));
        check("oor_v",     line_lp'(v_o),         line_lp'(1'b0));
        check("oor_ready", line_lp'(seg_ready_o), line_lp'(1'b1));
        drive_write(3'd1, w_lp'(8'h11));
        step();
        idle_inputs();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        check("oor_flush_v",   line_lp'(v_o),   line_lp'(1'b1));
        check("oor_flush_sel", line_lp'(sel_o), line_lp'(5'b00010));
        check("oor_seg1",      line_lp'(data_o[255:128]), line_lp'(8'h11));
`ifdef BSG_SEGMENTED_FILL_ZERO_EN
        exp_seg = '0;
        check("oor_seg2_zero", line_lp'(data_o[383:256]), line_lp'(0));
`else
        exp_seg = w_lp'(8'hA0);
        check("oor_seg2_stale", line_lp'(data_o[383:256]), line_lp'(8'h66));
`endif

        // DONE ignores writes and flushes for three cycles
        for (int i = 0; i < 3; i++) begin
            drive_write(3'd0, w_lp'(16'hDEAD));
            flush_i = 1'b1;
            step();
            #1;
            check("hold_sel",   line_lp'(sel_o),         line_lp'(5'b00010));
            check("hold_seg0",  line_lp'(data_o[127:0]), line_lp'(exp_seg));
            check("hold_seg1",  line_lp'(data_o[255:128]), line_lp'(8'h11));
            check("hold_ready", line_lp'(seg_ready_o),   line_lp'(1'b0));
            check("hold_v",     line_lp'(v_o),           line_lp'(1'b1));
        end
        idle_inputs();
        take_line();

        // Write and flush in the same cycle: write lands first, line completes
        drive_write(3'd4, w_lp'(8'h44));
        flush_i = 1'b1;
        step();
        idle_inputs();
        #1;
        check("wf_v",    line_lp'(v_o),   line_lp'(1'b1));
        check("wf_sel",  line_lp'(sel_o), line_lp'(5'b10000));
        check("wf_seg4", line_lp'(data_o[639:512]), line_lp'(8'h44));

        // Reset while a line is offered drops v_o
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        #1;
        check("rst_done_v",   line_lp'(v_o),   line_lp'(1'b0));
        check("rst_done_sel", line_lp'(sel_o), line_lp'(5'b00000));

        // Partial line discarded by reset, then an empty flush is ignored
        drive_write(3'd0, w_lp'(8'h01));
        step();
        drive_write(3'd3, w_lp'(8'h03));
        step();
        idle_inputs();
        #1;
        check("partial_sel", line_lp'(sel_o), line_lp'(5'b01001));
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        #1;
        check("partial_rst_sel", line_lp'(sel_o), line_lp'(5'b00000));
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        check("empty_flush_v",     line_lp'(v_o),         line_lp'(1'b0));
        check("empty_flush_sel",   line_lp'(sel_o),       line_lp'(5'b00000));
        check("empty_flush_ready", line_lp'(seg_ready_o), line_lp'(1'b1));
        step();
        check("empty_flush_v_late", line_lp'(v_o), line_lp'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
